dbguart_phy: RTL and testbench

Byte-level UART physical stage of the debug UART path, directly upstream of the debug UART operator. It serialises bytes written by the operator onto `uart_txd` and deserialises `uart_rxd` into bytes for the operator. The frame format is 8N1, LSB first. Each direction has a small FIFO, and the bit period is set by the operator's `baudrate` output. The interface mirrors the operator's UART-side ports one-to-one.

---
 rtl/dbguart_phy.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_dbguart_phy.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbguart_phy.sv
// 8N1 UART physical stage for the debug UART path: TX/RX FIFOs, bit-period
// clamp, and serialiser/deserialiser. Define DBGUART_LOOPBACK_EN to enable internal loopback.
module dbguart_phy #(
  parameter int RXDEPTH = 4,
  parameter int TXDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baudrate,
  input  logic [7:0]  uart_control,
  input  logic [7:0]  txdata,
  input  logic        write_tx,
  output logic        tx_empty,
  output logic [7:0]  rxdata,
  output logic        rx_valid,
  input  logic        read_rx,
  output logic [7:0]  status,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int unsigned RXAW = $clog2(RXDEPTH);
  localparam int unsigned TXAW = $clog2(TXDEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  logic        rx_en, tx_en, clr_err;
  logic [15:0] n_eff;
  logic        unused_ctrl;

  assign rx_en   = uart_control[0];
  assign tx_en   = uart_control[1];
  assign clr_err = uart_control[3];
  assign n_eff   = (baudrate < 16'd4) ? 16'd4 : baudrate;

  // ---------------- TX FIFO ----------------
  logic [7:0]      tx_mem_q [TXDEPTH];
  logic [TXAW-1:0] tx_wr_q, tx_rd_q;
  logic [TXAW:0]   tx_lvl_q;
  logic            tx_full, tx_push, tx_pop;

  assign tx_full  = (tx_lvl_q == (TXAW+1)'(TXDEPTH));
  assign tx_empty = (tx_lvl_q == '0);
  assign tx_push  = write_tx & ~tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_lvl_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + TXAW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + TXAW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_lvl_q <= tx_lvl_q + (TXAW+1)'(1);
        2'b01:   tx_lvl_q <= tx_lvl_q - (TXAW+1)'(1);
        default: tx_lvl_q <= tx_lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= txdata;
  end

  // ---------------- TX FSM ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_tick_q, tx_tick_d, tx_n_q, tx_n_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_last, tx_go, tx_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_n_q     <= 16'd4;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_n_q     <= tx_n_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  assign tx_last = (tx_tick_q == tx_n_q - 16'd1);
  assign tx_go   = tx_en & ~tx_empty;

  // Final stop-bit cycle chains straight into the next start bit, so frames abut.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q + 16'd1;
    tx_n_d     = tx_n_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_tick_d = '0;
        if (tx_go) begin
          tx_state_d = TX_START;
          tx_sh_d    = tx_mem_q[tx_rd_q];
          tx_n_d     = n_eff;
          tx_pop     = 1'b1;
        end
      end
      TX_START: begin
        if (tx_last) begin
          tx_state_d = TX_DATA;
          tx_tick_d  = '0;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_last) begin
          tx_tick_d = '0;
          tx_sh_d   = {1'b0, tx_sh_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: begin
        if (tx_last) begin
          tx_tick_d = '0;
          if (tx_go) begin
            tx_state_d = TX_START;
            tx_sh_d    = tx_mem_q[tx_rd_q];
            tx_n_d     = n_eff;
            tx_pop     = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    uart_txd = 1'b1;
    case (tx_state_q)
      TX_START: uart_txd = 1'b0;
      TX_DATA:  uart_txd = tx_sh_q[0];
      default:  uart_txd = 1'b1;
    endcase
    tx_busy = (tx_state_q != TX_IDLE);
  end

  // ---------------- RX input path ----------------
  logic sync1_q, sync2_q, rx_prev_q, rx_line, rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= uart_rxd;
      sync2_q   <= sync1_q;
      rx_prev_q <= rx_line;
    end
  end

`ifdef DBGUART_LOOPBACK_EN
  assign rx_line     = uart_control[2] ? uart_txd : sync2_q;
  assign unused_ctrl = ^uart_control[7:4];
`else
  assign rx_line     = sync2_q;
  assign unused_ctrl = ^{uart_control[7:4], uart_control[2]};
`endif

  assign rx_fall = rx_prev_q & ~rx_line;

  // ---------------- RX FIFO ----------------
  logic [7:0]      rx_mem_q [RXDEPTH];
  logic [RXAW-1:0] rx_wr_q, rx_rd_q;
  logic [RXAW:0]   rx_lvl_q;
  logic            rx_full, rx_push, rx_pop, rx_done, ovr_set, ferr_set;

  assign rx_full  = (rx_lvl_q == (RXAW+1)'(RXDEPTH));
  assign rx_valid = (rx_lvl_q != '0);
  assign rxdata   = rx_mem_q[rx_rd_q];
  assign rx_pop   = read_rx & rx_valid;
  assign rx_push  = rx_done & (~rx_full | rx_pop);
  assign ovr_set  = rx_done & rx_full & ~rx_pop;

  // ---------------- RX FSM ----------------
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_tick_q, rx_tick_d, rx_n_q, rx_n_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        ovr_q, ferr_q, rx_last, rx_half, rx_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_n_q     <= 16'd4;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_lvl_q   <= '0;
      for (int unsigned i = 0; i < RXDEPTH; i++) rx_mem_q[i] <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_n_q     <= rx_n_d;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
      ovr_q      <= (ovr_q & ~clr_err) | ovr_set;
      ferr_q     <= (ferr_q & ~clr_err) | ferr_set;
      if (rx_push) begin
        rx_mem_q[rx_wr_q] <= rx_sh_q;
        rx_wr_q           <= rx_wr_q + RXAW'(1);
      end
      if (rx_pop) rx_rd_q <= rx_rd_q + RXAW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_lvl_q <= rx_lvl_q + (RXAW+1)'(1);
        2'b01:   rx_lvl_q <= rx_lvl_q - (RXAW+1)'(1);
        default: rx_lvl_q <= rx_lvl_q;
      endcase
    end
  end

  assign rx_last = (rx_tick_q == rx_n_q - 16'd1);
  assign rx_half = (rx_tick_q == (rx_n_q >> 1) - 16'd1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q + 16'd1;
    rx_n_d     = rx_n_q;
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    rx_done    = 1'b0;
    ferr_set   = 1'b0;
    if (!rx_en) begin
      rx_state_d = RX_IDLE;
      rx_tick_d  = '0;
    end else begin
      unique case (rx_state_q)
        RX_IDLE: begin
          rx_tick_d = '0;
          if (rx_fall) begin
            rx_state_d = RX_START;
            rx_n_d     = n_eff;
          end
        end
        RX_START: begin
          if (rx_half) begin
            rx_tick_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_line ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_last) begin
            rx_tick_d = '0;
            rx_sh_d   = {rx_line, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_last) begin
            rx_tick_d = '0;
            if (rx_line) begin
              rx_done    = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
              ferr_set   = 1'b1;
              rx_state_d = RX_WAIT;
            end
          end
        end
        RX_WAIT: begin
          rx_tick_d = '0;
          if (rx_line) rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy = (rx_state_q != RX_IDLE);
    status  = {rx_busy, ferr_q, ovr_q, tx_busy, tx_full, tx_empty, rx_full, rx_valid};
  end

endmodule

// File: tb/tb_dbguart_phy.sv
// Directed self-checking bench for dbguart_phy; loopback case runs when
// DBGUART_LOOPBACK_EN is defined.
module tb_dbguart_phy;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baudrate;
  logic [7:0]  uart_control;
  logic [7:0]  txdata;
  logic        write_tx;
  logic        tx_empty;
  logic [7:0]  rxdata;
  logic        rx_valid;
  logic        read_rx;
  logic [7:0]  status;
  logic        uart_rxd;
  logic        uart_txd;

  always #5 clk = ~clk;

  dbguart_phy #(.RXDEPTH(4), .TXDEPTH(4)) dut (
    .clk(clk), .rst(rst), .baudrate(baudrate), .uart_control(uart_control),
    .txdata(txdata), .write_tx(write_tx), .tx_empty(tx_empty),
    .rxdata(rxdata), .rx_valid(rx_valid), .read_rx(read_rx),
    .status(status), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  logic cap [0:255];
  int   cap_idx = 0;
  logic cap_on  = 1'b0;
  int   busy_cnt = 0;
  int   rv_at;

  always @(negedge clk) begin
    if (cap_on) begin
      if (cap_idx < 256) cap[cap_idx] = uart_txd;
      cap_idx = cap_idx + 1;
      if (status[4]) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] exp_frame(input logic [7:0] b, input int n);
    logic [159:0] v;
    v = '0;
    for (int k = 0; k < 10 * n; k++) begin
      int j;
      j = k / n;
      if (j == 0)      v[k] = 1'b0;
      else if (j == 9) v[k] = 1'b1;
      else             v[k] = b[j-1];
    end
    return v;
  endfunction

  task automatic check_frame(input string tag, input int base, input logic [7:0] b, input int n);
    logic [159:0] got;
    logic [159:0] exp;
    got = '0;
    for (int k = 0; k < 10 * n; k++) got[k] = cap[base + k];
    exp = exp_frame(b, n);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, input int n);
    logic [9:0] fr;
    int t;
    fr = {stopb, b, 1'b0};
    t = 0;
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (n) begin
        tick();
        t++;
        if (rx_valid && rv_at < 0) rv_at = t;
      end
    end
    uart_rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    uart_control = 8'h0B;
    tick();
    uart_control = 8'h03;
  endtask

  initial begin
    logic [7:0] ovr_bytes [5];
    logic [7:0] b2b_bytes [5];
    ovr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    b2b_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

    rst = 1'b1; baudrate = 16'd16; uart_control = 8'h00; txdata = 8'h00;
    write_tx = 1'b0; read_rx = 1'b0; uart_rxd = 1'b1;
    ticks(3);
    check("rst_txd", 32'(uart_txd), 32'h1);
    check("rst_tx_empty", 32'(tx_empty), 32'h1);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_rxdata", 32'(rxdata), 32'h00);
    check("rst_status", 32'(status), 32'h04);
    rst = 1'b0;
    ticks(2);

    // TX frame 0xA5 at 16 clocks/bit
    uart_control = 8'h03;
    txdata = 8'hA5; write_tx = 1'b1;
    tick();
    write_tx = 1'b0;
    check("tx_empty_fall", 32'(tx_empty), 32'h0);
    check("txd_t1_idle", 32'(uart_txd), 32'h1);
    tick();
    cap_idx = 0; busy_cnt = 0; cap_on = 1'b1;
    check("txd_t2_start", 32'(uart_txd), 32'h0);
    check("tx_empty_rise", 32'(tx_empty), 32'h1);
    ticks(165);
    cap_on = 1'b0;
    check_frame("tx_frame_a5", 0, 8'hA5, 16);
    check("tx_busy_len", 32'(busy_cnt), 32'd160);
    check("tx_after_idle", 32'(cap[160]), 32'h1);

    // RX frame 0x3C at 8 clocks/bit
    baudrate = 16'd8;
    rv_at = -1;
    send_rx(8'h3C, 1'b1, 8);
    check("rx_latency", 32'(rv_at), 32'd79);
    check("rx_valid", 32'(rx_valid), 32'h1);
    check("rx_data_3c", 32'(rxdata), 32'h3C);
    read_rx = 1'b1; tick(); read_rx = 1'b0;
    check("rx_valid_pop", 32'(rx_valid), 32'h0);
    read_rx = 1'b1; tick(); read_rx = 1'b0;
    check("rx_pop_empty", 32'(status), 32'h04);

    // 3-clock glitch: false start
    uart_rxd = 1'b0; ticks(3); uart_rxd = 1'b1;
    ticks(30);
    check("rx_glitch", 32'(status), 32'h04);

    // Framing error
    send_rx(8'h55, 1'b0, 8);
    ticks(5);
    check("ferr_set", 32'(status), 32'h44);
    pulse_clr();
    check("ferr_clr", 32'(status), 32'h04);

    // Overrun: 5 bytes into a 4-deep FIFO
    for (int i = 0; i < 5; i++) send_rx(ovr_bytes[i], 1'b1, 8);
    ticks(5);
    check("ovr_status", 32'(status), 32'h27);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr_data%0d", i), 32'(rxdata), 32'(ovr_bytes[i]));
      read_rx = 1'b1; tick(); read_rx = 1'b0;
    end
    check("ovr_drained", 32'(rx_valid), 32'h0);
    pulse_clr();
    check("ovr_clr", 32'(status), 32'h04);

    // Back-to-back with baud clamp (2 -> 4)
    baudrate = 16'd2;
    txdata = b2b_bytes[0]; write_tx = 1'b1;
    tick();
    txdata = b2b_bytes[1];
    tick();
    cap_idx = 0; busy_cnt = 0; cap_on = 1'b1;
    txdata = b2b_bytes[2];
    tick();
    txdata = b2b_bytes[3];
    tick();
    txdata = b2b_bytes[4];
    tick();
    check("b2b_full", 32'(status), 32'h18);
    txdata = 8'hEE;
    tick();
    write_tx = 1'b0;
    check("b2b_drop", 32'(status), 32'h18);
    ticks(200);
    cap_on = 1'b0;
    for (int f = 0; f < 5; f++)
      check_frame($sformatf("b2b_frame%0d", f), 40 * f, b2b_bytes[f], 4);
    check("b2b_busy_len", 32'(busy_cnt), 32'd200);
    check("b2b_idle", 32'(cap[200]), 32'h1);
    check("b2b_empty", 32'(tx_empty), 32'h1);

`ifdef DBGUART_LOOPBACK_EN
    begin
      int waited;
      baudrate = 16'd8;
      uart_rxd = 1'b0;
      uart_control = 8'h07;
      txdata = 8'hC3; write_tx = 1'b1;
      tick();
      write_tx = 1'b0;
      waited = 0;
      while (!rx_valid && waited < 200) begin
        tick();
        waited++;
      end
      check("lb_valid", 32'(rx_valid), 32'h1);
      check("lb_data", 32'(rxdata), 32'hC3);
      check("lb_ferr", 32'(status[6]), 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
